// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W_BITS = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
    localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

    // Register match that never fires on $0.
    function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline control bundle between the datapath/controller and the hazard unit.
interface hazard_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD;
    logic regwriteE, memtoregE, hiloreadE, divE;
    logic regwriteM, memtoregM, memreadM, memwriteM, hilowriteM, mem_ready;
    logic regwriteW, hilowriteW;

    logic stallF, stallD, stallE, stallM, stallW, flushE;
    logic forwardaD, forwardbD;
    logic [FWD_W_BITS-1:0] forwardaE, forwardbE, forwardhiloE;
    logic div_start, div_busy;

    modport master (
        output rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE, hiloreadE, divE,
               writeregM, regwriteM, memtoregM, memreadM, memwriteM, hilowriteM, mem_ready,
               writeregW, regwriteW, hilowriteW,
        input  stallF, stallD, stallE, stallM, stallW, flushE, forwardaD, forwardbD,
               forwardaE, forwardbE, forwardhiloE, div_start, div_busy
    );

    modport slave (
        input  rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE, hiloreadE, divE,
               writeregM, regwriteM, memtoregM, memreadM, memwriteM, hilowriteM, mem_ready,
               writeregW, regwriteW, hilowriteW,
        output stallF, stallD, stallE, stallM, stallW, flushE, forwardaD, forwardbD,
               forwardaE, forwardbE, forwardhiloE, div_start, div_busy
    );

endinterface

// File: rtl/div_stall_fsm.sv
// Fixed-latency divide wait FSM: launches the external divider and freezes the pipe until it finishes.
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 36
) (
    input  logic clk,
    input  logic rst,
    input  logic div_e,
    input  logic memstall,
    output logic div_start,
    output logic div_busy,
    output logic divstall
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait phase is DIV_CYCLES-1 cycles so launch + wait equals the divider latency.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        case (state_q)
            RUN: begin
                if (div_e) begin
                    div_start = 1'b1;
                    state_d   = DIV_WAIT;
                    cnt_d     = CNT_W'(DIV_CYCLES - 1);
                end
            end
            DIV_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                // Hold here while the finished divide is still frozen in E.
                if (!memstall) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        div_busy = (state_q != RUN);
        divstall = (state_q == DIV_WAIT) || div_start;
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding control for the 5-stage MIPS pipeline.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 36
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hif
);

    logic lwstall, branchstall, memstall, divstall, freeze, div_start, div_busy;
    logic [FWD_W_BITS-1:0] fwd_a_e, fwd_b_e, fwd_hilo_e;

    div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .div_e     (hif.divE),
        .memstall  (memstall),
        .div_start (div_start),
        .div_busy  (div_busy),
        .divstall  (divstall)
    );

    // Forwarding selects; M is the younger producer and wins over W.
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (hif.regwriteM && reg_hit(hif.writeregM, hif.rsE))      fwd_a_e = FWD_M;
        else if (hif.regwriteW && reg_hit(hif.writeregW, hif.rsE)) fwd_a_e = FWD_W;
        if (hif.regwriteM && reg_hit(hif.writeregM, hif.rtE))      fwd_b_e = FWD_M;
        else if (hif.regwriteW && reg_hit(hif.writeregW, hif.rtE)) fwd_b_e = FWD_W;
        fwd_hilo_e = FWD_RF;
        if (hif.hiloreadE) begin
            if (hif.hilowriteM)      fwd_hilo_e = FWD_M;
            else if (hif.hilowriteW) fwd_hilo_e = FWD_W;
        end
    end

    always_comb begin
        lwstall     = hif.memtoregE &&
                      (reg_hit(hif.writeregE, hif.rsD) || reg_hit(hif.writeregE, hif.rtD));
        branchstall = hif.branchD &&
                      ((hif.regwriteE &&
                        (reg_hit(hif.writeregE, hif.rsD) || reg_hit(hif.writeregE, hif.rtD))) ||
                       (hif.memtoregM &&
                        (reg_hit(hif.writeregM, hif.rsD) || reg_hit(hif.writeregM, hif.rtD))));
        memstall    = (hif.memreadM || hif.memwriteM) && !hif.mem_ready;
        // Memory and divide waits freeze every stage; no bubble is needed.
        freeze      = memstall || divstall;
    end

    assign hif.stallF       = lwstall || branchstall || freeze;
    assign hif.stallD       = lwstall || branchstall || freeze;
    assign hif.stallE       = freeze;
    assign hif.stallM       = freeze;
    assign hif.stallW       = freeze;
    assign hif.flushE       = (lwstall || branchstall) && !freeze;
    assign hif.forwardaD    = hif.regwriteM && reg_hit(hif.writeregM, hif.rsD);
    assign hif.forwardbD    = hif.regwriteM && reg_hit(hif.writeregM, hif.rtD);
    assign hif.forwardaE    = fwd_a_e;
    assign hif.forwardbE    = fwd_b_e;
    assign hif.forwardhiloE = fwd_hilo_e;
    assign hif.div_start    = div_start;
    assign hif.div_busy     = div_busy;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized checks of hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int unsigned DIV_CYCLES = 4;

    logic clk;
    logic rst;
    hazard_if hif ();

    hazard_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_stall_e = 0;

    // Model of the divide: frozen cycles still owed after launch, then a done phase.
    int freeze_rem = 0;
    bit done_phase = 0;

    logic [1:0] e_fae, e_fbe, e_fhilo;
    logic e_fad, e_fbd, e_stall_fd, e_freeze, e_flush, e_start, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Oldest-to-youngest scan; the last matching producer is the youngest and wins.
    function automatic logic [1:0] fwd_src(input logic [4:0] src);
        logic [1:0] sel;
        logic [4:0] dst [2];
        bit         wr [2];
        logic [1:0] code [2];
        dst[0] = hif.writeregW; wr[0] = hif.regwriteW; code[0] = 2'b01;
        dst[1] = hif.writeregM; wr[1] = hif.regwriteM; code[1] = 2'b10;
        sel = 2'b00;
        for (int i = 0; i < 2; i++)
            if (wr[i] && hit(dst[i], src)) sel = code[i];
        return sel;
    endfunction

    task automatic model_eval();
        bit memst, lw, br, dstall;
        memst   = (hif.memreadM || hif.memwriteM) && !hif.mem_ready;
        lw      = hif.memtoregE && (hit(hif.writeregE, hif.rsD) || hit(hif.writeregE, hif.rtD));
        br      = hif.branchD &&
                  ((hif.regwriteE && (hit(hif.writeregE, hif.rsD) || hit(hif.writeregE, hif.rtD))) ||
                   (hif.memtoregM && (hit(hif.writeregM, hif.rsD) || hit(hif.writeregM, hif.rtD))));
        e_busy  = (freeze_rem > 0) || done_phase;
        e_start = !e_busy && hif.divE;
        dstall  = (freeze_rem > 0) || e_start;
        e_freeze   = memst || dstall;
        e_stall_fd = lw || br || e_freeze;
        e_flush    = (lw || br) && !e_freeze;
        e_fae   = fwd_src(hif.rsE);
        e_fbe   = fwd_src(hif.rtE);
        e_fad   = hif.regwriteM && hit(hif.writeregM, hif.rsD);
        e_fbd   = hif.regwriteM && hit(hif.writeregM, hif.rtD);
        e_fhilo = !hif.hiloreadE ? 2'b00 : hif.hilowriteM ? 2'b10 : hif.hilowriteW ? 2'b01 : 2'b00;
    endtask

    task automatic model_clock();
        bit memst;
        memst = (hif.memreadM || hif.memwriteM) && !hif.mem_ready;
        if (!rst) begin
            freeze_rem = 0;
            done_phase = 0;
        end else if (freeze_rem > 0) begin
            freeze_rem--;
            if (freeze_rem == 0) done_phase = 1;
        end else if (done_phase) begin
            if (!memst) done_phase = 0;
        end else if (hif.divE) begin
            freeze_rem = DIV_CYCLES - 1;
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("stallF", 32'(hif.stallF), 32'(e_stall_fd));
        chk("stallD", 32'(hif.stallD), 32'(e_stall_fd));
        chk("stallE", 32'(hif.stallE), 32'(e_freeze));
        chk("stallM", 32'(hif.stallM), 32'(e_freeze));
        chk("stallW", 32'(hif.stallW), 32'(e_freeze));
        chk("flushE", 32'(hif.flushE), 32'(e_flush));
        chk("forwardaD", 32'(hif.forwardaD), 32'(e_fad));
        chk("forwardbD", 32'(hif.forwardbD), 32'(e_fbd));
        chk("forwardaE", 32'(hif.forwardaE), 32'(e_fae));
        chk("forwardbE", 32'(hif.forwardbE), 32'(e_fbe));
        chk("forwardhiloE", 32'(hif.forwardhiloE), 32'(e_fhilo));
        chk("div_start", 32'(hif.div_start), 32'(e_start));
        chk("div_busy", 32'(hif.div_busy), 32'(e_busy));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        n_start   += int'(hif.div_start);
        n_stall_e += int'(hif.stallE);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        {hif.rsD, hif.rtD, hif.rsE, hif.rtE} = '0;
        {hif.writeregE, hif.writeregM, hif.writeregW} = '0;
        {hif.branchD, hif.regwriteE, hif.memtoregE, hif.hiloreadE, hif.divE} = '0;
        {hif.regwriteM, hif.memtoregM, hif.memreadM, hif.memwriteM, hif.hilowriteM} = '0;
        {hif.regwriteW, hif.hilowriteW} = '0;
        hif.mem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #3;
        check_all();
        chk("reset_div_busy", 32'(hif.div_busy), 32'd0);
        step();
        rst = 1'b1;

        // Forward priority M over W, then W alone.
        hif.regwriteM = 1; hif.writeregM = 5'd8;
        hif.regwriteW = 1; hif.writeregW = 5'd8; hif.rsE = 5'd8;
        #1 chk("fwd_prio_M", 32'(hif.forwardaE), 32'd2);
        step();
        hif.writeregM = 5'd9;
        #1 chk("fwd_W_only", 32'(hif.forwardaE), 32'd1);
        step();

        // $0 never forwards.
        clear_inputs();
        hif.regwriteM = 1; hif.regwriteW = 1; hif.regwriteE = 1;
        #1 chk("zero_reg_fwdE", 32'({hif.forwardaE, hif.forwardbE}), 32'd0);
        chk("zero_reg_fwdD", 32'({hif.forwardaD, hif.forwardbD}), 32'd0);
        step();

        // Load-use: one bubble cycle, then the load moves on.
        clear_inputs();
        hif.memtoregE = 1; hif.writeregE = 5'd5; hif.rtD = 5'd5;
        #1 chk("lu_stallF", 32'(hif.stallF), 32'd1);
        chk("lu_flushE", 32'(hif.flushE), 32'd1);
        chk("lu_stallE", 32'(hif.stallE), 32'd0);
        step();
        hif.memtoregE = 0;
        #1 chk("lu_released", 32'({hif.stallF, hif.flushE}), 32'd0);
        step();

        // Divide: one launch pulse, DIV_CYCLES frozen cycles, a done cycle with divE still held.
        clear_inputs();
        n_start = 0; n_stall_e = 0;
        hif.divE = 1;
        for (int i = 0; i < int'(DIV_CYCLES) + 1; i++) step();
        chk("div_start_pulses", 32'(n_start), 32'd1);
        chk("div_stallE_cycles", 32'(n_stall_e), 32'(DIV_CYCLES));
        hif.divE = 0;
        step();
        chk("div_back_to_run", 32'(hif.div_busy), 32'd0);

        // Memory wait during the divide wait phase.
        hif.memreadM = 1; hif.mem_ready = 1;
        n_start = 0; n_stall_e = 0;
        hif.divE = 1;
        step(); step();
        hif.mem_ready = 0;
        step(); step(); step();
        hif.mem_ready = 1;
        step();
        chk("divmem_stallE_cycles", 32'(n_stall_e), 32'd5);
        chk("divmem_start_pulses", 32'(n_start), 32'd1);
        hif.divE = 0; hif.memreadM = 0;
        step();

        // Async reset in the middle of a divide, then a fresh launch.
        hif.divE = 1;
        step(); step();
        #2 rst = 1'b0;
        freeze_rem = 0; done_phase = 0;
        #1 chk("async_rst_busy", 32'(hif.div_busy), 32'd0);
        hif.divE = 0;
        step();
        rst = 1'b1;
        n_start = 0;
        hif.divE = 1;
        step();
        chk("relaunch_start", 32'(n_start), 32'd1);
        hif.divE = 0;
        for (int i = 0; i < int'(DIV_CYCLES) + 1; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
            hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
            hif.writeregE = 5'($urandom_range(0, 3));
            hif.writeregM = 5'($urandom_range(0, 3));
            hif.writeregW = 5'($urandom_range(0, 3));
            hif.branchD   = 1'($urandom_range(0, 1));
            hif.regwriteE = 1'($urandom_range(0, 1));
            hif.memtoregE = 1'($urandom_range(0, 1));
            hif.hiloreadE = 1'($urandom_range(0, 1));
            hif.divE      = ($urandom_range(0, 7) == 0);
            hif.regwriteM = 1'($urandom_range(0, 1));
            hif.memtoregM = 1'($urandom_range(0, 1));
            hif.memreadM  = 1'($urandom_range(0, 1));
            hif.memwriteM = 1'($urandom_range(0, 1));
            hif.hilowriteM = 1'($urandom_range(0, 1));
            hif.mem_ready = ($urandom_range(0, 3) != 0);
            hif.regwriteW = 1'($urandom_range(0, 1));
            hif.hilowriteW = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
